// File: rtl/fir_output_decimator.sv
// fir_output_decimator: rounds, shifts and saturates the full-precision FIR
// output to the system sample width, decimates by DECIM, and buffers kept
// samples in a small show-ahead FIFO with a valid/ready output.
module fir_output_decimator #(
    parameter int IN_WIDTH   = 31,
    parameter int OUT_WIDTH  = 12,
    parameter int SHIFT      = 7,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 clr,
    input  logic                                 in_valid,
    input  logic [IN_WIDTH-1:0]                  filtered_signal,
    output logic [OUT_WIDTH-1:0]                 out_sample,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic                                 sat_flag,
    output logic                                 overflow
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [IN_WIDTH:0] RND_BIAS  = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MAX   = {{(IN_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN   = {{(IN_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
    localparam logic [LW-1:0]            FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0]            CNT_LAST  = CW'(DECIM - 1);

    logic signed [IN_WIDTH:0] rnd_sum;
    logic signed [IN_WIDTH:0] shifted;
    logic                     clamp_hi;
    logic                     clamp_lo;
    logic [OUT_WIDTH-1:0]     sat_sample;

    logic                     st_valid;
    logic [OUT_WIDTH-1:0]     st_sample;

    logic [CW-1:0]            dec_cnt;
    logic                     keep;

    logic [OUT_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [LW-1:0]            level;
    logic                     fifo_full;
    logic                     push;
    logic                     pop;
    logic                     drop;

    // Round, arithmetic shift and clamp the incoming filter output.
    always_comb begin
        rnd_sum  = $signed({filtered_signal[IN_WIDTH-1], filtered_signal}) + RND_BIAS;
        shifted  = rnd_sum >>> SHIFT;
        clamp_hi = shifted > SAT_MAX;
        clamp_lo = shifted < SAT_MIN;
        if (clamp_hi) begin
            sat_sample = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else if (clamp_lo) begin
            sat_sample = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end else begin
            sat_sample = shifted[OUT_WIDTH-1:0];
        end
    end

    // Stage register: loads every cycle, valid mirrors in_valid.
    always_ff @(posedge clk) begin
        if (!clr) begin
            st_valid  <= 1'b0;
            st_sample <= '0;
        end else begin
            st_valid  <= in_valid;
            st_sample <= sat_sample;
        end
    end

    // Decimation counter advances only on valid stage entries; count 0 keeps.
    always_ff @(posedge clk) begin
        if (!clr) begin
            dec_cnt <= '0;
        end else if (st_valid) begin
            dec_cnt <= (dec_cnt == CNT_LAST) ? '0 : dec_cnt + CW'(1);
        end
    end

    // FIFO control: a pop on the same edge frees the slot for a push when full.
    always_comb begin
        keep      = st_valid && (dec_cnt == '0);
        fifo_full = (level == FULL_LVL);
        out_valid = (level != '0);
        pop       = out_valid && out_ready;
        push      = keep && (!fifo_full || pop);
        drop      = keep && fifo_full && !pop;
    end

    // FIFO storage; contents are irrelevant while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= st_sample;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky status flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!clr) begin
            sat_flag <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sat_flag <= sat_flag | (in_valid & (clamp_hi | clamp_lo));
            overflow <= overflow | drop;
        end
    end

    // Show-ahead head sample, forced to zero while empty.
    always_comb begin
        out_sample = out_valid ? mem[rd_ptr] : '0;
        fifo_level = level;
    end

endmodule

// File: tb/tb_fir_output_decimator.sv
// Self-checking bench for fir_output_decimator: directed scenarios plus a
// randomized run against a transaction-level reference model. Two instances
// (DECIM = 1 and DECIM = 2) share the stimulus; sel picks the one under test.
module tb_fir_output_decimator;

    localparam int IW = 31;
    localparam int OW = 12;
    localparam int SH = 7;
    localparam int FD = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          clr;
    logic          in_valid;
    logic          out_ready;
    logic [IW-1:0] filtered_signal;

    logic [OW-1:0] d1_sample, d2_sample;
    logic          d1_valid, d2_valid;
    logic [LW-1:0] d1_level, d2_level;
    logic          d1_sat, d2_sat;
    logic          d1_ovf, d2_ovf;

    int                   sel = 1;
    logic signed [OW-1:0] o_sample;
    logic                 o_valid;
    logic [LW-1:0]        o_level;
    logic                 o_sat;
    logic                 o_ovf;

    // Reference model state: FIFO contents, stage entry, valid count since reset.
    int mq[$];
    bit m_st_v;
    int m_st_x;
    int m_vcnt;
    bit m_sat;
    bit m_ovf;
    int m_decim = 1;

    int got[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_output_decimator #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DECIM(1), .FIFO_DEPTH(FD)
    ) u_d1 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .filtered_signal(filtered_signal),
        .out_sample(d1_sample), .out_valid(d1_valid), .out_ready(out_ready),
        .fifo_level(d1_level), .sat_flag(d1_sat), .overflow(d1_ovf)
    );

    fir_output_decimator #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DECIM(2), .FIFO_DEPTH(FD)
    ) u_d2 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .filtered_signal(filtered_signal),
        .out_sample(d2_sample), .out_valid(d2_valid), .out_ready(out_ready),
        .fifo_level(d2_level), .sat_flag(d2_sat), .overflow(d2_ovf)
    );

    // Route the selected instance to the observation signals.
    always_comb begin
        if (sel == 1) begin
            o_sample = d1_sample; o_valid = d1_valid; o_level = d1_level;
            o_sat = d1_sat; o_ovf = d1_ovf;
        end else begin
            o_sample = d2_sample; o_valid = d2_valid; o_level = d2_level;
            o_sat = d2_sat; o_ovf = d2_ovf;
        end
    end

    // Ideal conversion: floor((x + 64) / 128), clamped to the 12-bit range.
    function automatic int ref_conv(input longint x, output bit clamped);
        longint s, q;
        s = x + 64;
        q = s / 128;
        if ((s % 128) != 0 && s < 0) q = q - 1;
        clamped = 1'b0;
        if (q > 2047) begin
            q = 2047; clamped = 1'b1;
        end else if (q < -2048) begin
            q = -2048; clamped = 1'b1;
        end
        return int'(q);
    endfunction

    // One clock: drive inputs, log a pop, advance the model, settle.
    task automatic cyc(input bit c, input bit v, input longint x, input bit r);
        bit pop, keep, full, cl;
        int y;
        clr = c; in_valid = v; filtered_signal = IW'(x); out_ready = r;
        if (c && o_valid && r) got.push_back(int'(o_sample));
        @(posedge clk);
        if (!c) begin
            mq.delete(); m_st_v = 0; m_vcnt = 0; m_sat = 0; m_ovf = 0;
        end else begin
            pop  = (mq.size() > 0) && r;
            full = (mq.size() == FD);
            keep = m_st_v && ((m_vcnt % m_decim) == 0);
            if (m_st_v) m_vcnt++;
            if (pop) void'(mq.pop_front());
            if (keep) begin
                if (full && !pop) m_ovf = 1;
                else mq.push_back(m_st_x);
            end
            y = ref_conv(x, cl);
            m_st_v = v; m_st_x = y;
            if (v && cl) m_sat = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        got.delete();
    endtask

    task automatic test_reset();
        sel = 1; m_decim = 1;
        cyc(0, 1, 12345, 1);
        cyc(0, 1, -777, 1);
        n_checks++; if (d1_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_d1_valid: got %0b want 0", d1_valid); end
        n_checks++; if (d1_sample !== '0)   begin n_fail++; $display("FAIL reset_d1_sample: got %0d want 0", d1_sample); end
        n_checks++; if (d1_level !== '0)    begin n_fail++; $display("FAIL reset_d1_level: got %0d want 0", d1_level); end
        n_checks++; if (d1_sat !== 1'b0)    begin n_fail++; $display("FAIL reset_d1_sat: got %0b want 0", d1_sat); end
        n_checks++; if (d1_ovf !== 1'b0)    begin n_fail++; $display("FAIL reset_d1_ovf: got %0b want 0", d1_ovf); end
        n_checks++; if (d2_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_d2_valid: got %0b want 0", d2_valid); end
        n_checks++; if (d2_level !== '0)    begin n_fail++; $display("FAIL reset_d2_level: got %0d want 0", d2_level); end
        n_checks++; if (d2_sat !== 1'b0)    begin n_fail++; $display("FAIL reset_d2_sat: got %0b want 0", d2_sat); end
        got.delete();
    endtask

    task automatic test_rounding();
        longint vin[5] = '{192, -192, 64, -64, 63};
        int     exp[5] = '{2, -1, 1, 0, 0};
        sel = 1; m_decim = 1;
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 1, vin[i], 1);
        repeat (4) cyc(1, 0, 0, 1);
        n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL round_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_fail++; $display("FAIL round_out%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : 9999, exp[i]);
            end
        end
        n_checks++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL round_sat: got %0b want 0", o_sat); end
    endtask

    task automatic test_saturation();
        int exp[2] = '{2047, -2048};
        sel = 1; m_decim = 1;
        do_reset();
        cyc(1, 1, 64'sd1 <<< 20, 1);
        cyc(1, 1, -(64'sd1 <<< 20), 1);
        repeat (4) cyc(1, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_fail++; $display("FAIL sat_out%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : 9999, exp[i]);
            end
        end
        n_checks++; if (o_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag_set: got %0b want 1", o_sat); end
        repeat (5) cyc(1, 1, 100, 1);
        n_checks++; if (o_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag_sticky: got %0b want 1", o_sat); end
        do_reset();
        n_checks++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL sat_flag_clear: got %0b want 0", o_sat); end
    endtask

    task automatic test_decimation();
        int exp[5] = '{0, 2, 4, 6, 8};
        sel = 2; m_decim = 2;
        do_reset();
        for (int k = 0; k < 8; k++) cyc(1, 1, 128 * k, 1);
        repeat (3) cyc(1, 0, 0, 1);
        cyc(1, 1, 128 * 8, 1);
        cyc(1, 1, 128 * 9, 1);
        repeat (4) cyc(1, 0, 0, 1);
        n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL decim_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_fail++; $display("FAIL decim_out%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : 9999, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        sel = 1; m_decim = 1;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            cyc(1, 1, 128 * i, 0);
            if (i == 5) begin
                n_checks++; if (o_level !== 3'd4) begin n_fail++; $display("FAIL bp_level_full: got %0d want 4", o_level); end
                n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_early: got %0b want 0", o_ovf); end
            end
            if (i == 6) begin
                n_checks++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_set: got %0b want 1", o_ovf); end
            end
        end
        repeat (2) cyc(1, 0, 0, 0);
        n_checks++; if (o_level !== 3'd4) begin n_fail++; $display("FAIL bp_level_hold: got %0d want 4", o_level); end
        got.delete();
        repeat (6) cyc(1, 0, 0, 1);
        n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== i + 1) begin
                n_fail++; $display("FAIL bp_out%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : 9999, i + 1);
            end
        end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty_valid: got %0b want 0", o_valid); end
        n_checks++; if (o_sample !== '0) begin n_fail++; $display("FAIL bp_empty_sample: got %0d want 0", o_sample); end
    endtask

    task automatic test_full_push_pop();
        sel = 1; m_decim = 1;
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            cyc(1, 1, 128 * i, i >= 6);
            if (i >= 5) begin
                n_checks++; if (o_level !== 3'd4) begin n_fail++; $display("FAIL fpp_level%0d: got %0d want 4", i, o_level); end
                n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf%0d: got %0b want 0", i, o_ovf); end
            end
        end
        repeat (8) cyc(1, 0, 0, 1);
        n_checks++; if (got.size() != 14) begin n_fail++; $display("FAIL fpp_count: got %0d want 14", got.size()); end
        for (int i = 0; i < 14; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== i + 1) begin
                n_fail++; $display("FAIL fpp_out%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : 9999, i + 1);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int budget = 0;
        int i = 1;
        sel = 2; m_decim = 2;
        do_reset();
        while (o_level != 3'd3 && budget < 20) begin
            cyc(1, 1, 128 * i, 0);
            i++; budget++;
        end
        n_checks++; if (o_level !== 3'd3) begin n_fail++; $display("FAIL mid_fill: got %0d want 3 (budget expired)", o_level); end
        cyc(0, 1, 128 * 50, 0);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0b want 0", o_valid); end
        n_checks++; if (o_sample !== '0) begin n_fail++; $display("FAIL mid_rst_sample: got %0d want 0", o_sample); end
        n_checks++; if (o_level !== '0) begin n_fail++; $display("FAIL mid_rst_level: got %0d want 0", o_level); end
        n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf: got %0b want 0", o_ovf); end
        cyc(1, 1, 640, 0);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat1_valid: got %0b want 0", o_valid); end
        cyc(1, 0, 0, 0);
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_lat2_valid: got %0b want 1", o_valid); end
        n_checks++; if (o_sample !== 12'sd5) begin n_fail++; $display("FAIL mid_lat2_sample: got %0d want 5", o_sample); end
    endtask

    task automatic test_random();
        logic [IW-1:0] raw;
        longint x;
        bit c, v, r;
        int exp_s;
        for (int s = 1; s <= 2; s++) begin
            sel = s; m_decim = s;
            do_reset();
            for (int n = 0; n < 1500; n++) begin
                c = ($urandom_range(0, 199) != 0);
                v = ($urandom_range(0, 99) < 70);
                r = ($urandom_range(0, 99) < 55);
                if ($urandom_range(0, 9) == 0) begin
                    raw = IW'($urandom);
                    x = longint'($signed(raw));
                end else begin
                    x = longint'($urandom_range(0, 1 << 19)) - (64'sd1 <<< 18);
                end
                cyc(c, v, x, r);
                exp_s = (mq.size() > 0) ? mq[0] : 0;
                n_checks++; if (o_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b want %0b", n, o_valid, mq.size() > 0); end
                n_checks++; if (int'(o_sample) !== exp_s) begin n_fail++; $display("FAIL rnd_sample@%0d: got %0d want %0d", n, o_sample, exp_s); end
                n_checks++; if (int'(o_level) !== mq.size()) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d want %0d", n, o_level, mq.size()); end
                n_checks++; if (o_sat !== m_sat) begin n_fail++; $display("FAIL rnd_sat@%0d: got %0b want %0b", n, o_sat, m_sat); end
                n_checks++; if (o_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", n, o_ovf, m_ovf); end
            end
        end
    endtask

    initial begin
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; filtered_signal = '0;
        #1;
        test_reset();
        test_rounding();
        test_saturation();
        test_decimation();
        test_backpressure();
        test_full_push_pop();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
